// File: rtl/score_sequencer.sv
// score_sequencer: steps through a score held in an external synchronous ROM.
// Each ROM word is {dur[11:8], note[7:0]}. Every note plays for dur ticks, and an
// articulation gap (mute) is flagged over the tail of its final tick. A word with
// dur==0 marks the end of the score, as does running past the last ROM address.
module score_sequencer #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 16,
  parameter int GAP_CYC = 2500000,
  parameter int AW      = 6
) (
  input  logic          iclk,
  input  logic          irst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic [AW-1:0] rom_addr,
  input  logic [11:0]   rom_data,
  output logic [7:0]    code,
  output logic          mute,
  output logic          busy,
  output logic          done
);

  localparam int TICK_CYC = CLK_HZ / TICK_HZ;
  localparam int CW       = $clog2(TICK_CYC);
  localparam int CW1      = CW + 1;
  // Last value of the cycle counter within one tick.
  localparam logic [CW-1:0] CYC_LAST  = CW'(TICK_CYC - 1);
  // First cycle of the final tick that falls inside the articulation gap.
  // One extra bit so that GAP_CYC==0 (start == TICK_CYC) is never reached.
  localparam logic [CW:0]   GAP_START = CW1'(TICK_CYC - GAP_CYC);
  localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_PLAY  = 2'd3
  } state_t;

  // Replace any note outside the playable ranges (0, 1-7, 11-17, 21-27) by a rest.
  function automatic logic [7:0] validate_note(input logic [7:0] note);
    logic ok;
    ok = (note <= 8'd7) ||
         ((note >= 8'd11) && (note <= 8'd17)) ||
         ((note >= 8'd21) && (note <= 8'd27));
    return ok ? note : 8'd0;
  endfunction

  state_t        state_r, state_s;
  logic [AW-1:0] addr_r, addr_s;
  logic [7:0]    code_r, code_s;
  logic          mute_r, mute_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic [CW-1:0] cyc_r, cyc_s;
  logic [3:0]    tick_r, tick_s;
  logic          eos_s;
  logic [3:0]    dur_s;
  logic [7:0]    note_s;

  assign dur_s  = rom_data[11:8];
  assign note_s = rom_data[7:0];

  // Next-state, counter and output computation; outputs are derived from next values
  // so that the registered outputs line up with the state they describe.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    code_s  = code_r;
    cyc_s   = cyc_r;
    tick_s  = tick_r;
    done_s  = 1'b0;
    eos_s   = 1'b0;

    if (stop) begin
      state_s = S_IDLE;
      addr_s  = '0;
      code_s  = 8'd0;
      cyc_s   = '0;
      tick_s  = 4'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_s = S_FETCH;
            addr_s  = '0;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_FETCH: begin
          state_s = S_LOAD;
        end
        S_LOAD: begin
          if (dur_s == 4'd0) begin
            eos_s = 1'b1;
          end else begin
            code_s  = validate_note(note_s);
            tick_s  = dur_s;
            cyc_s   = '0;
            state_s = S_PLAY;
          end
        end
        S_PLAY: begin
          if (cyc_r == CYC_LAST) begin
            cyc_s  = '0;
            tick_s = tick_r - 4'd1;
            if (tick_r == 4'd1) begin
              if (addr_r == ADDR_LAST) begin
                eos_s = 1'b1;
              end else begin
                addr_s  = addr_r + {{(AW-1){1'b0}}, 1'b1};
                state_s = S_FETCH;
              end
            end else begin
              state_s = S_PLAY;
            end
          end else begin
            cyc_s = cyc_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_s = S_IDLE;
          addr_s  = '0;
          code_s  = 8'd0;
          cyc_s   = '0;
          tick_s  = 4'd0;
        end
      endcase

      // End of score: either restart from the top or finish with a done pulse.
      if (eos_s) begin
        addr_s = '0;
        cyc_s  = '0;
        tick_s = 4'd0;
        if (loop) begin
          state_s = S_FETCH;
        end else begin
          state_s = S_IDLE;
          code_s  = 8'd0;
          done_s  = 1'b1;
        end
      end else begin
        done_s = 1'b0;
      end
    end

    busy_s = (state_s != S_IDLE);
    mute_s = (state_s != S_PLAY) || (code_s == 8'd0) ||
             ((tick_s == 4'd1) && ({1'b0, cyc_s} >= GAP_START));
  end

  // State, counters and registered outputs.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_r <= S_IDLE;
      addr_r  <= '0;
      code_r  <= 8'd0;
      mute_r  <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cyc_r   <= '0;
      tick_r  <= 4'd0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      code_r  <= code_s;
      mute_r  <= mute_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      cyc_r   <= cyc_s;
      tick_r  <= tick_s;
    end
  end

  assign rom_addr = addr_r;
  assign code     = code_r;
  assign mute     = mute_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule
